int_controller_n: RTL and testbench
===================================

# int_controller_n

Parametrised N-channel interrupt arbiter between peripheral interrupt lines and the processor's single interrupt port. Per-channel masking, fixed-priority or round-robin arbitration, and the processor handshake (C_IACK, C_IEND) routed to the one granted channel. It is the generalised successor of the two-channel controller. It sits between the peripheral IRQ sources and the CPU interrupt logic.

## Interface
- NUM_IRQ, 4: number of peripheral channels (2..16).
- ID_W, $clog2(NUM_IRQ): width of the channel id.
- RR_EN, 0: 0 = fixed priority (channel 0 highest); 1 = round-robin.
- MASK_RST, {NUM_IRQ{1'b0}}: reset value of the mask register (1 = masked).
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- C_IRQ_VALID  out  1  interrupt request to the processor.
- C_IRQ_ID  out  ID_W  id of the requesting channel; meaningful only while C_IRQ_VALID=1.
- C_IACK  in  1  processor acknowledge.
- C_IEND  in  1  processor end-of-service; held high until the controller releases.
- IRQ  in  NUM_IRQ  level-sensitive peripheral requests, active-high.
- IACK  out  NUM_IRQ  per-channel acknowledge.
- IEND  out  NUM_IRQ  per-channel end-of-service.
- MASK_WE  in  1  mask write strobe.
- MASK_WDATA  in  NUM_IRQ  new mask value.
- MASK  out  NUM_IRQ  current mask register.
- BUSY  out  1  high in any state other than IDLE.

## Operation
- States:
  - IDLE: eligible = IRQ & ~MASK. If any bit is set, latch the winner into id_q and go to REQ. Otherwise stay in IDLE.
  - REQ:
    - C_IRQ_VALID = IRQ[id_q] & ~MASK[id_q], combinational.
    - If that term is 0, the request is withdrawn: go to IDLE.
    - Else if C_IACK, go to SERVE.
    - Else stay in REQ.
  - SERVE: if C_IEND, go to ENDHOLD. Otherwise stay. IRQ and MASK changes are ignored.
  - ENDHOLD: if ~C_IEND, go to IDLE and advance the round-robin pointer. Otherwise stay.
- Arbitration:
  - Fixed priority: the lowest-index eligible channel wins.
  - Round-robin: search starts at rr_ptr and wraps modulo NUM_IRQ.
  - rr_ptr becomes id_q+1 (wrapping to 0 after NUM_IRQ-1) only on ENDHOLD→IDLE. A withdrawal does not advance it.
- Routing: in REQ, SERVE and ENDHOLD, IACK[id_q] = C_IACK and IEND[id_q] = C_IEND, combinationally. All other IACK/IEND bits are 0. In IDLE, all IACK/IEND bits are 0.
- C_IRQ_ID = id_q in every state.
- MASK register: written with MASK_WDATA on the clock edge where MASK_WE=1, in any state. A write to the granted channel's bit while in REQ causes withdrawal on the next evaluation. The same write while in SERVE or ENDHOLD has no effect on the in-flight service.
- State encoding is unconstrained. Unused encodings return to IDLE.

## Timing
- Reset (RESET_N low, asynchronous): state=IDLE, id_q=0, rr_ptr=0, MASK=MASK_RST. All outputs: C_IRQ_VALID=0, C_IRQ_ID=0, IACK=0, IEND=0, BUSY=0. Reset mid-service aborts with no IEND pulse.
- Request latency: IRQ sampled high at edge k → C_IRQ_VALID=1 after edge k (one cycle).
- C_IACK sampled at edge m while in REQ with valid=1 → SERVE after m. IACK[id_q] mirrors C_IACK in the same cycle.
- C_IEND high at edge n in SERVE → ENDHOLD. IEND[id_q] stays high as long as C_IEND stays high.
- C_IEND low at edge p → IDLE after p. The earliest next C_IRQ_VALID is after p+1.
- Minimum full transaction: 4 cycles, IRQ to IDLE.
- Simultaneous events:
  - Withdrawal and C_IACK in the same REQ cycle: withdrawal wins. IACK[id_q] still mirrors C_IACK that cycle.
  - C_IEND during REQ is ignored.
  - C_IACK during SERVE or ENDHOLD is forwarded but has no effect on state.
  - IRQ arriving on other channels while BUSY stays pending (level) and is arbitrated at the next IDLE.

## Test plan
- Reset with MASK_RST=4'b0010 → every output 0 and MASK=4'b0010. Assert RESET_N low mid-SERVE → next cycle IDLE, IEND=0.
- Fixed priority, NUM_IRQ=4: IRQ=4'b1010 → C_IRQ_ID=1 and IACK=4'b0010 on C_IACK. Full handshake → return to IDLE, then C_IRQ_ID=3.
- Round-robin, IRQ=4'b1111 held, four complete handshakes → grant order 0,1,2,3, then 0 again on wrap.
- Withdrawal: drop IRQ[2] while in REQ → C_IRQ_VALID=0 that cycle and IDLE next. With RR_EN=1, rr_ptr is unchanged.
- Mask: MASK_WE with MASK_WDATA=4'b0001 while channel 0 is in REQ → withdrawal, and channel 1 is granted next. The same write during SERVE → service completes and IEND[0] pulses.
- Hold C_IEND high for 5 cycles → IEND[id] high for all 5 cycles, state stays ENDHOLD, and the next request is not visible until 1 cycle after C_IEND falls.

Source files
------------

// File: rtl/int_controller_n.sv
// int_controller_n: N-channel interrupt arbiter in front of the CPU's single
// interrupt port, with per-channel mask and fixed or round-robin priority.
//
// Ports:
//   CLK, RESET_N      clock, asynchronous active-low reset
//   IRQ[N]            level-sensitive peripheral requests
//   MASK_WE/WDATA     mask register write; MASK shows current mask (1=masked)
//   C_IRQ_VALID/ID    request and channel id towards the processor
//   C_IACK, C_IEND    processor handshake, routed to IACK/IEND[id]
//   BUSY              controller is not idle
module int_controller_n #(
    parameter int                 NUM_IRQ  = 4,
    parameter int                 ID_W     = $clog2(NUM_IRQ),
    parameter bit                 RR_EN    = 1'b0,
    parameter logic [NUM_IRQ-1:0] MASK_RST = '0
) (
    input  logic               CLK,
    input  logic               RESET_N,
    output logic               C_IRQ_VALID,
    output logic [ID_W-1:0]    C_IRQ_ID,
    input  logic               C_IACK,
    input  logic               C_IEND,
    input  logic [NUM_IRQ-1:0] IRQ,
    output logic [NUM_IRQ-1:0] IACK,
    output logic [NUM_IRQ-1:0] IEND,
    input  logic               MASK_WE,
    input  logic [NUM_IRQ-1:0] MASK_WDATA,
    output logic [NUM_IRQ-1:0] MASK,
    output logic               BUSY
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SERVE,
        S_ENDHOLD
    } state_t;

    state_t               state_q;
    logic [ID_W-1:0]      id_q;
    logic [ID_W-1:0]      rr_ptr_q;
    logic [NUM_IRQ-1:0]   mask_q;

    logic [NUM_IRQ-1:0]   elig;
    logic                 any_elig;
    logic [ID_W-1:0]      win;
    logic                 found;
    int                   base;
    int                   j;
    logic [ID_W-1:0]      idx;
    logic                 req_live;
    logic [ID_W-1:0]      ptr_nxt;
    logic [NUM_IRQ-1:0]   sel;

    assign elig     = IRQ & ~mask_q;
    assign any_elig = |elig;

    // Scan from the start channel upwards, wrapping; first hit wins.
    // Fixed priority is simply a scan that always starts at channel 0.
    always_comb begin
        win   = '0;
        found = 1'b0;
        base  = RR_EN ? int'(rr_ptr_q) : 0;
        j     = 0;
        idx   = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            j = base + i;
            if (j >= NUM_IRQ) begin
                j = j - NUM_IRQ;
            end
            idx = ID_W'(j);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // The granted request stays alive only while its line is high and unmasked.
    assign req_live = IRQ[id_q] & ~mask_q[id_q];

    assign ptr_nxt = (id_q == ID_W'(NUM_IRQ - 1)) ? '0 : id_q + ID_W'(1);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            id_q     <= '0;
            rr_ptr_q <= '0;
            mask_q   <= MASK_RST;
        end else begin
            if (MASK_WE) begin
                mask_q <= MASK_WDATA;
            end
            case (state_q)
                S_IDLE: begin
                    if (any_elig) begin
                        id_q    <= win;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Withdrawal takes precedence over a same-cycle acknowledge.
                    if (!req_live) begin
                        state_q <= S_IDLE;
                    end else if (C_IACK) begin
                        state_q <= S_SERVE;
                    end
                end
                S_SERVE: begin
                    if (C_IEND) begin
                        state_q <= S_ENDHOLD;
                    end
                end
                S_ENDHOLD: begin
                    // Only a completed service moves the round-robin pointer.
                    if (!C_IEND) begin
                        state_q  <= S_IDLE;
                        rr_ptr_q <= ptr_nxt;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign BUSY        = (state_q != S_IDLE);
    assign C_IRQ_VALID = (state_q == S_REQ) & req_live;
    assign C_IRQ_ID    = id_q;
    assign MASK        = mask_q;

    assign sel  = BUSY ? (NUM_IRQ'(1) << id_q) : '0;
    assign IACK = sel & {NUM_IRQ{C_IACK}};
    assign IEND = sel & {NUM_IRQ{C_IEND}};

endmodule

// File: tb/tb_int_controller_n.sv
// tb_int_controller_n: fixed-priority and round-robin instances driven in
// lockstep, checked every cycle against a transaction-level model.
module tb_int_controller_n;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic [3:0] irq;
    logic       c_iack;
    logic       c_iend;
    logic       mask_we;
    logic [3:0] mask_wdata;

    logic [1:0]       o_valid;
    logic [1:0]       o_busy;
    logic [1:0][1:0]  o_id;
    logic [1:0][3:0]  o_iack;
    logic [1:0][3:0]  o_iend;
    logic [1:0][3:0]  o_mask;

    int n_chk = 0;
    int n_pass = 0;

    always #5 CLK = ~CLK;

    int_controller_n #(
        .NUM_IRQ(4), .RR_EN(1'b0), .MASK_RST(4'b0010)
    ) u_fix (
        .CLK(CLK), .RESET_N(rst_n),
        .C_IRQ_VALID(o_valid[0]), .C_IRQ_ID(o_id[0]),
        .C_IACK(c_iack), .C_IEND(c_iend), .IRQ(irq),
        .IACK(o_iack[0]), .IEND(o_iend[0]),
        .MASK_WE(mask_we), .MASK_WDATA(mask_wdata),
        .MASK(o_mask[0]), .BUSY(o_busy[0])
    );

    int_controller_n #(
        .NUM_IRQ(4), .RR_EN(1'b1), .MASK_RST(4'b0010)
    ) u_rr (
        .CLK(CLK), .RESET_N(rst_n),
        .C_IRQ_VALID(o_valid[1]), .C_IRQ_ID(o_id[1]),
        .C_IACK(c_iack), .C_IEND(c_iend), .IRQ(irq),
        .IACK(o_iack[1]), .IEND(o_iend[1]),
        .MASK_WE(mask_we), .MASK_WDATA(mask_wdata),
        .MASK(o_mask[1]), .BUSY(o_busy[1])
    );

    // Model: a channel owns the port (m_own, -1 = none); it is either
    // waiting for ack, being serviced, or waiting for C_IEND to drop.
    int         m_own[2];
    bit         m_ack[2];
    bit         m_end[2];
    int         m_ptr[2];
    int         m_id[2];
    logic [3:0] m_mask[2];
    logic [3:0] el;

    function automatic int pick(logic [3:0] e, int start);
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (start + k) % 4;
            if (e[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_own[d]  = -1;
            m_ack[d]  = 1'b0;
            m_end[d]  = 1'b0;
            m_ptr[d]  = 0;
            m_id[d]   = 0;
            m_mask[d] = 4'b0010;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                for (int d = 0; d < 2; d++) begin
                    el = irq & ~m_mask[d];
                    if (m_own[d] < 0) begin
                        if (el != 4'b0) begin
                            m_own[d] = pick(el, (d == 1) ? m_ptr[d] : 0);
                            m_id[d]  = m_own[d];
                            m_ack[d] = 1'b0;
                            m_end[d] = 1'b0;
                        end
                    end else if (!m_ack[d]) begin
                        if (!(irq[m_own[d]] && !m_mask[d][m_own[d]]))
                            m_own[d] = -1;
                        else if (c_iack)
                            m_ack[d] = 1'b1;
                    end else if (!m_end[d]) begin
                        if (c_iend) m_end[d] = 1'b1;
                    end else if (!c_iend) begin
                        m_ptr[d] = (m_own[d] + 1) % 4;
                        m_own[d] = -1;
                    end
                    if (mask_we) m_mask[d] = mask_wdata;
                end
            end
        end
    end

    task automatic chk(input string nm, input int d,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d actual=%0h required=%0h",
                      nm, d, act, exp);
    endtask

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge CLK);
            for (int d = 0; d < 2; d++) begin
                bit         b;
                bit         v;
                logic [3:0] oh;
                b  = (m_own[d] >= 0);
                v  = b && !m_ack[d] && irq[m_own[d]] &&
                     !m_mask[d][m_own[d]];
                oh = b ? (4'b0001 << m_own[d]) : 4'b0000;
                chk("busy",  d, 32'(o_busy[d]),  32'(b));
                chk("valid", d, 32'(o_valid[d]), 32'(v));
                chk("id",    d, 32'(o_id[d]),    32'(m_id[d]));
                chk("iack",  d, 32'(o_iack[d]),  32'(oh & {4{c_iack}}));
                chk("iend",  d, 32'(o_iend[d]),  32'(oh & {4{c_iend}}));
                chk("mask",  d, 32'(o_mask[d]),  32'(m_mask[d]));
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic serve(input int hold, input logic [3:0] nirq);
        c_iack = 1'b1;
        step();
        c_iack = 1'b0;
        c_iend = 1'b1;
        irq    = nirq;
        repeat (hold) step();
        c_iend = 1'b0;
        step();
    endtask

    initial begin
        irq = 4'b0; c_iack = 1'b0; c_iend = 1'b0;
        mask_we = 1'b0; mask_wdata = 4'b0; rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) step();
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_mask",  d, 32'(o_mask[d]),  32'h2);
            chk("rst_valid", d, 32'(o_valid[d]), 32'h0);
            chk("rst_busy",  d, 32'(o_busy[d]),  32'h0);
            chk("rst_id",    d, 32'(o_id[d]),    32'h0);
            chk("rst_iack",  d, 32'(o_iack[d]),  32'h0);
            chk("rst_iend",  d, 32'(o_iend[d]),  32'h0);
        end
        rst_n = 1'b1;

        // Fixed priority 1010 -> channel 1, then channel 3.
        step(); mask_we = 1'b1; mask_wdata = 4'b0;
        step(); mask_we = 1'b0;
        irq = 4'b1010;
        step(); #1;
        chk("fp_valid", 0, 32'(o_valid[0]), 32'h1);
        chk("fp_id1",   0, 32'(o_id[0]),    32'h1);
        chk("fp_id1",   1, 32'(o_id[1]),    32'h1);
        c_iack = 1'b1; #1;
        chk("fp_iack", 0, 32'(o_iack[0]), 32'h2);
        step(); c_iack = 1'b0; c_iend = 1'b1; irq = 4'b1000; #1;
        chk("fp_iend", 0, 32'(o_iend[0]), 32'h2);
        step(); c_iend = 1'b0;
        step();
        step(); #1;
        chk("fp_id3", 0, 32'(o_id[0]), 32'h3);
        chk("fp_id3", 1, 32'(o_id[1]), 32'h3);
        serve(1, 4'b0);

        // Round-robin grant order with all lines held.
        irq = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step(); #1;
            chk("rr_order", 1, 32'(o_id[1]), 32'(i % 4));
            chk("fp_hold",  0, 32'(o_id[0]), 32'h0);
            serve(1, 4'b1111);
        end
        irq = 4'b0;

        // Withdrawal with simultaneous ack; pointer must not move.
        irq = 4'b0100;
        step(); #1;
        chk("wd_id", 1, 32'(o_id[1]), 32'h2);
        irq = 4'b0; c_iack = 1'b1; #1;
        chk("wd_valid", 0, 32'(o_valid[0]), 32'h0);
        chk("wd_valid", 1, 32'(o_valid[1]), 32'h0);
        chk("wd_iack",  0, 32'(o_iack[0]),  32'h4);
        step(); c_iack = 1'b0; #1;
        chk("wd_idle", 0, 32'(o_busy[0]), 32'h0);
        chk("wd_idle", 1, 32'(o_busy[1]), 32'h0);
        irq = 4'b1111;
        step(); #1;
        chk("wd_ptr", 1, 32'(o_id[1]), 32'h1);
        irq = 4'b0;
        step();

        // Masking the granted channel while requesting.
        irq = 4'b0011;
        step(); #1;
        chk("mk_id0", 0, 32'(o_id[0]), 32'h0);
        mask_we = 1'b1; mask_wdata = 4'b0001;
        step(); mask_we = 1'b0; #1;
        chk("mk_wd",   0, 32'(o_valid[0]), 32'h0);
        chk("mk_mask", 0, 32'(o_mask[0]),  32'h1);
        step(); #1;
        chk("mk_idle", 0, 32'(o_busy[0]), 32'h0);
        step(); #1;
        chk("mk_id1",    0, 32'(o_id[0]),    32'h1);
        chk("mk_valid1", 0, 32'(o_valid[0]), 32'h1);
        serve(1, 4'b0);

        // Same mask write during service leaves the service intact.
        mask_we = 1'b1; mask_wdata = 4'b0;
        step(); mask_we = 1'b0; irq = 4'b0001;
        step();
        c_iack = 1'b1;
        step();
        c_iack = 1'b0; c_iend = 1'b1;
        mask_we = 1'b1; mask_wdata = 4'b0001; irq = 4'b0; #1;
        chk("ms_iend", 0, 32'(o_iend[0]), 32'h1);
        step(); mask_we = 1'b0; #1;
        chk("ms_iend2", 0, 32'(o_iend[0]), 32'h1);
        chk("ms_busy",  0, 32'(o_busy[0]), 32'h1);
        c_iend = 1'b0;
        step(); #1;
        chk("ms_idle", 0, 32'(o_busy[0]), 32'h0);

        // C_IEND held for 5 cycles with another request pending.
        mask_we = 1'b1; mask_wdata = 4'b0;
        step(); mask_we = 1'b0; irq = 4'b0100;
        step();
        c_iack = 1'b1;
        step();
        c_iack = 1'b0; c_iend = 1'b1; irq = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("eh_iend",  0, 32'(o_iend[0]),  32'h4);
            chk("eh_valid", 0, 32'(o_valid[0]), 32'h0);
            step();
        end
        c_iend = 1'b0; #1;
        chk("eh_busy", 0, 32'(o_busy[0]), 32'h1);
        step(); #1;
        chk("eh_novalid", 0, 32'(o_valid[0]), 32'h0);
        chk("eh_idle",    0, 32'(o_busy[0]),  32'h0);
        step(); #1;
        chk("eh_next", 0, 32'(o_valid[0]), 32'h1);
        chk("eh_id3",  0, 32'(o_id[0]),    32'h3);

        // Reset in the middle of a service.
        c_iack = 1'b1;
        step();
        c_iack = 1'b0; c_iend = 1'b1; irq = 4'b0; #1;
        chk("rs_busy", 0, 32'(o_busy[0]), 32'h1);
        rst_n = 1'b0; #1;
        chk("rs_idle", 0, 32'(o_busy[0]), 32'h0);
        chk("rs_iend", 0, 32'(o_iend[0]), 32'h0);
        chk("rs_id",   0, 32'(o_id[0]),   32'h0);
        chk("rs_mask", 0, 32'(o_mask[0]), 32'h2);
        step();
        rst_n = 1'b1; c_iend = 1'b0;

        // Random traffic, checked cycle by cycle against the model.
        repeat (3000) begin
            step();
            irq        = 4'($urandom_range(0, 15));
            c_iack     = ($urandom_range(0, 2) == 0);
            c_iend     = ($urandom_range(0, 2) == 0);
            mask_we    = ($urandom_range(0, 7) == 0);
            mask_wdata = 4'($urandom_range(0, 15));
            rst_n      = ($urandom_range(0, 199) != 0);
        end
        step();
        rst_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
